// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   dm_type encodings (funct3 of loads/stores), reused by the decoder and
//   the writeback mux, the LSU FSM state encoding, and small helpers that
//   classify an access and build store strobes / lane-replicated data.
package lsu_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_byte(input logic [2:0] t);
    return (t == DM_B) || (t == DM_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return (t == DM_H) || (t == DM_HU);
  endfunction

  // Anything that is neither a byte nor a halfword access (including the
  // undefined encodings) is handled as a full word.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] lo);
    if (is_byte(t)) return 1'b0;
    if (is_half(t)) return lo[0];
    return lo != 2'b00;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] t, input logic [1:0] lo);
    if (is_byte(t)) return 4'b0001 << lo;
    if (is_half(t)) return 4'b0011 << lo;
    return 4'b1111;
  endfunction

  // Replicating the store data across all lanes lets the strobes alone pick
  // the destination bytes, so no lane shifter is needed on the write path.
  function automatic logic [31:0] store_data(input logic [2:0] t, input logic [31:0] wd);
    if (is_byte(t)) return {4{wd[7:0]}};
    if (is_half(t)) return {2{wd[15:0]}};
    return wd;
  endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext -- combinational load lane select and extension.
//   word    : 32-bit word returned by data memory
//   lo      : byte offset (addr[1:0]) of the access
//   dm_type : funct3 access type
//   data    : selected byte/halfword, sign- or zero-extended; words pass through
module load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave it unassigned and infer a latch.
    lane_b = word[7:0];
    lane_h = lo[1] ? word[31:16] : word[15:0];
    data   = word;

    case (lo)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase

    case (dm_type)
      DM_B:    data = {{24{lane_b[7]}}, lane_b};
      DM_BU:   data = {24'd0, lane_b};
      DM_H:    data = {{16{lane_h[15]}}, lane_h};
      DM_HU:   data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem -- MEM-stage load/store unit.
//   Pipeline side : mem_req, mem_we, dm_type, addr, wdata in;
//                   dout (extended load data), done (completion pulse),
//                   stall (freeze IF..MEM), misalign (combinational) out.
//   Memory side   : m_valid/m_ready request handshake carrying m_we,
//                   m_addr (word aligned), m_wstrb, m_wdata; m_rvalid/m_rdata
//                   response for loads.
//   Sequence IDLE -> REQ -> (RESP for loads) -> DONE -> IDLE. DATA_W must be 32.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wstrb,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  lsu_state_e        state;
  logic [1:0]        lat_lo;     // byte offset of the access in flight
  logic [2:0]        lat_type;   // dm_type of the access in flight
  logic [DATA_W-1:0] load_word;

  assign misalign = mem_req & misaligned(dm_type, addr[1:0]);

  // Already high in the IDLE cycle where the request shows up, so the
  // pipeline freezes before the FSM has even left IDLE.
  assign stall = mem_req & ~misalign & (state != DONE);

  load_ext u_load_ext (
    .word    (m_rdata),
    .lo      (lat_lo),
    .dm_type (lat_type),
    .data    (load_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lat_lo   <= '0;
      lat_type <= '0;
      dout     <= '0;
      done     <= 1'b0;
      m_valid  <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wstrb  <= '0;
      m_wdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on the values from before the edge, regardless of order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req && !misalign) begin
            state    <= REQ;
            lat_lo   <= addr[1:0];
            lat_type <= dm_type;
            m_valid  <= 1'b1;
            m_we     <= mem_we;
            m_addr   <= {addr[ADDR_W-1:2], 2'b00};
            m_wstrb  <= mem_we ? store_strb(dm_type, addr[1:0]) : 4'b0000;
            m_wdata  <= store_data(dm_type, wdata);
          end
        end
        REQ: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_we) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          // m_rvalid is only looked at here; strays in other states are dropped.
          if (m_rvalid) begin
            dout  <= load_word;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
